// File: rtl/apb_req_arbiter.sv
// Purpose : round-robin arbiter that funnels four requesters onto one APB master,
//           with per-transfer stall timeout and abort.
// Latency : grant registered one cycle after an eligible req in IDLE; m_new the same cycle;
//           done/err pulse the cycle after the completing or timing-out enable cycle.
// Backpressure: pready low stretches WAIT; after TIMEOUT stalled enable cycles the transfer is aborted.
// Ports   : clk/preset (sync, active-high); req/req_wr/req_addr/req_wdata packed per requester;
//           penable/pready/prdata observed from the APB bus; m_* drive the APB master;
//           gnt/done/err/rdata/busy report back to the requesters.
module apb_req_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        preset,
  input  logic [3:0]  req,
  input  logic [3:0]  req_wr,
  input  logic [11:0] req_addr,
  input  logic [19:0] req_wdata,
  input  logic        penable,
  input  logic        pready,
  input  logic [4:0]  prdata,
  output logic        m_new,
  output logic        m_wr,
  output logic [2:0]  m_addr,
  output logic [4:0]  m_wdata,
  output logic        m_rst,
  output logic [3:0]  gnt,
  output logic [3:0]  done,
  output logic [3:0]  err,
  output logic [4:0]  rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t     state;
  logic [1:0] last_gnt;
  logic [1:0] cur_idx;
  logic [3:0] cnt;

  logic [3:0] elig;
  logic       win_vld;
  logic [1:0] win_idx;

  // A requester whose done/err pulse is still visible is skipped this cycle,
  // so a held req cannot win again immediately after its own completion.
  // The loop walks from farthest to nearest so the entry just after
  // last_gnt overrides the rest.
  always_comb begin
    elig    = req & ~done & ~err;
    win_vld = 1'b0;
    win_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (elig[2'(int'(last_gnt) + k + 1)]) begin
        win_vld = 1'b1;
        win_idx = 2'(int'(last_gnt) + k + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (preset) begin
      state    <= IDLE;
      last_gnt <= 2'd3;
      cur_idx  <= 2'd0;
      cnt      <= 4'd0;
      m_new    <= 1'b0;
      m_wr     <= 1'b0;
      m_addr   <= 3'd0;
      m_wdata  <= 5'd0;
      m_rst    <= 1'b0;
      gnt      <= 4'd0;
      done     <= 4'd0;
      err      <= 4'd0;
      rdata    <= 5'd0;
      busy     <= 1'b0;
    end else begin
      // single-cycle strobes default low
      m_new <= 1'b0;
      m_rst <= 1'b0;
      done  <= 4'd0;
      err   <= 4'd0;

      case (state)
        IDLE: begin
          if (win_vld) begin
            state   <= ISSUE;
            busy    <= 1'b1;
            gnt     <= 4'b0001 << win_idx;
            cur_idx <= win_idx;
            m_wr    <= req_wr[win_idx];
            m_addr  <= req_addr[int'(win_idx)*3 +: 3];
            m_wdata <= req_wdata[int'(win_idx)*5 +: 5];
            m_new   <= 1'b1;
            cnt     <= 4'd0;
          end
        end

        ISSUE: begin
          state <= WAIT;
        end

        WAIT: begin
          // pready is only meaningful in the enable phase; checking pready
          // first gives completion priority over a coincident timeout.
          if (penable) begin
            if (pready) begin
              done     <= gnt;
              rdata    <= m_wr ? 5'd0 : prdata;
              gnt      <= 4'd0;
              last_gnt <= cur_idx;
              state    <= IDLE;
              busy     <= 1'b0;
            end else if (cnt == 4'(TIMEOUT - 1)) begin
              // this stalled cycle brings the count to TIMEOUT: abort
              m_rst    <= 1'b1;
              err      <= gnt;
              rdata    <= 5'd0;
              gnt      <= 4'd0;
              last_gnt <= cur_idx;
              state    <= IDLE;
              busy     <= 1'b0;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end

        default: begin
          state <= IDLE;
          gnt   <= 4'd0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Purpose : randomized self-checking bench for apb_req_arbiter against a transaction-level model.
// Latency : n/a (bench); drives inputs and samples outputs on the falling edge.
// Backpressure: bench plays the APB bus, inserting random setup pready and enable-phase stalls.
module tb_apb_req_arbiter;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        preset;
  logic [3:0]  req;
  logic [3:0]  req_wr;
  logic [11:0] req_addr;
  logic [19:0] req_wdata;
  logic        penable;
  logic        pready;
  logic [4:0]  prdata;
  logic        m_new;
  logic        m_wr;
  logic [2:0]  m_addr;
  logic [4:0]  m_wdata;
  logic        m_rst;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [3:0]  err;
  logic [4:0]  rdata;
  logic        busy;

  apb_req_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .preset(preset), .req(req), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .penable(penable), .pready(pready), .prdata(prdata),
    .m_new(m_new), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata), .m_rst(m_rst),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // model state: who finished last, what rdata should currently hold
  int         mdl_last;
  logic [4:0] rd_exp;
  int         prev_new;
  logic [3:0] obs_gnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // round-robin: first asserted requester after the last one served
  function automatic int rr_pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++)
      if (r[(last + k) % 4]) return (last + k) % 4;
    return 0;
  endfunction

  // One complete arbitration + APB transfer. stalls >= TO forces a timeout.
  task automatic txn(input logic [3:0] r, input logic [3:0] wr, input logic [11:0] a,
                     input logic [19:0] wd, input int stalls, input logic [4:0] pd,
                     input bit drop);
    int         w;
    int         n;
    bit         seen;
    bit         quiet;
    bit         stable;
    bit         tmo;
    logic [3:0] g_exp;
    logic       wr_exp;
    logic [2:0] a_exp;
    logic [4:0] wd_exp;
    logic [4:0] res_exp;

    req = r; req_wr = wr; req_addr = a; req_wdata = wd;
    penable = 1'b0; pready = 1'b0;
    w      = rr_pick(r, mdl_last);
    g_exp  = 4'(1 << w);
    wr_exp = wr[w];
    a_exp  = a[3*w +: 3];
    wd_exp = wd[5*w +: 5];

    seen = 1'b0;
    for (int t = 0; t < 8 && !seen; t++) begin
      @(negedge clk);
      seen = m_new;
    end
    chk("grant_wait", 32'(seen), 1);
    if (!seen) return;

    obs_gnt = gnt;
    chk("gnt", gnt, g_exp);
    chk("m_wr", m_wr, wr_exp);
    chk("m_addr", m_addr, a_exp);
    chk("m_wdata", m_wdata, wd_exp);
    chk("busy", busy, 1);
    chk("pulse_clear", {done, err, m_rst}, 0);
    chk("rdata_hold", rdata, rd_exp);
    if (prev_new >= 0) chk("new_gap_ge4", 32'(cyc - prev_new >= 4), 1);
    prev_new = cyc;

    // disturb requester-side inputs once the command is latched
    if (drop) req[w] = 1'b0;
    req_wr    = 4'($urandom);
    req_addr  = 12'($urandom);
    req_wdata = 20'($urandom);

    quiet  = 1'b1;
    stable = 1'b1;
    tmo    = (stalls >= TO);
    n      = tmo ? TO : stalls + 1;
    // two cycles with penable low (ISSUE exit + APB setup), then n enable cycles
    for (int s = 0; s < 2 + n; s++) begin
      penable = (s >= 2);
      pready  = (s < 2) ? 1'($urandom) : (!tmo && s == n + 1);
      prdata  = (s == n + 1) ? pd : 5'($urandom);
      @(negedge clk);
      if (s < n + 1) begin
        if (done != 4'd0 || err != 4'd0 || m_rst || m_new || !busy) quiet = 1'b0;
        if (gnt !== g_exp || m_wr !== wr_exp || m_addr !== a_exp || m_wdata !== wd_exp)
          stable = 1'b0;
        if (s % 3 == 0) begin
          req_addr  = 12'($urandom);
          req_wdata = 20'($urandom);
        end
      end
    end

    chk("cmd_stable", 32'(stable), 1);
    chk("no_early_pulse", 32'(quiet), 1);
    res_exp = (tmo || wr_exp) ? 5'd0 : pd;
    chk("done", done, tmo ? 4'd0 : g_exp);
    chk("err", err, tmo ? g_exp : 4'd0);
    chk("m_rst", m_rst, 32'(tmo));
    chk("rdata", rdata, res_exp);
    chk("gnt_clear", gnt, 0);
    chk("busy_clear", busy, 0);
    mdl_last = w;
    rd_exp   = res_exp;
    penable  = 1'b0;
    pready   = 1'b0;
  endtask

  initial begin
    int         stalls;
    int         sel;
    bit         seen;
    logic [3:0] r;
    int         fair_seq [5];

    fair_seq = '{0, 1, 2, 3, 0};
    preset = 1'b1; req = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    penable = 1'b0; pready = 1'b0; prdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {gnt, done, err, m_new, m_rst, m_wr, m_addr, m_wdata, rdata, busy}, 0);
    preset   = 1'b0;
    mdl_last = 3;
    rd_exp   = 5'd0;
    prev_new = -1;

    // fairness with everyone requesting, starting from reset
    for (int i = 0; i < 5; i++) begin
      txn(4'hF, 4'($urandom), 12'($urandom), 20'($urandom), i, 5'($urandom), 1'b0);
      chk("fair_order", obs_gnt, 32'(1 << fair_seq[i]));
    end

    // single write from requester 0
    txn(4'b0001, 4'b0001, 12'h005, 20'h0001A, 0, 5'h1F, 1'b0);
    // single read from requester 2
    txn(4'b0100, 4'b0000, 12'h0C0, 20'h00000, 2, 5'h0B, 1'b0);
    // completion on the very cycle the counter would reach TIMEOUT
    txn(4'hF, 4'h0, 12'($urandom), 20'($urandom), TO - 1, 5'h15, 1'b0);
    // timeout, then the next requester in line
    txn(4'hF, 4'h0, 12'($urandom), 20'($urandom), TO, 5'h07, 1'b0);
    txn(4'hF, 4'h0, 12'($urandom), 20'($urandom), 1, 5'h0C, 1'b1);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      sel = int'($urandom % 8);
      if (sel < 5)       stalls = int'($urandom % 4);
      else if (sel == 5) stalls = TO - 2 + int'($urandom % 2);
      else if (sel == 6) stalls = TO;
      else               stalls = int'($urandom % 8);
      r = 4'($urandom_range(1, 15));
      txn(r, 4'($urandom), 12'($urandom), 20'($urandom), stalls, 5'($urandom), 1'($urandom));
    end

    // reset while stalled in WAIT
    req = 4'hF; req_wr = 4'hF; req_addr = 12'hFFF; req_wdata = 20'hFFFFF;
    seen = 1'b0;
    for (int t = 0; t < 8 && !seen; t++) begin
      @(negedge clk);
      seen = m_new;
    end
    chk("rst_test_grant", 32'(seen), 1);
    penable = 1'b0;
    @(negedge clk);
    penable = 1'b1; pready = 1'b0;
    @(negedge clk);
    preset = 1'b1;
    @(negedge clk);
    chk("reset_mid", {gnt, done, err, m_new, m_rst, m_wr, m_addr, m_wdata, rdata, busy}, 0);
    preset   = 1'b0;
    penable  = 1'b0;
    mdl_last = 3;
    rd_exp   = 5'd0;
    prev_new = -1;
    txn(4'hF, 4'h0, 12'($urandom), 20'($urandom), 0, 5'h11, 1'b0);
    chk("first_after_reset", obs_gnt, 4'b0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, which is the maximum number of enable-phase cycles with pready low before the transfer is aborted; legal range is 1..15.
REQ-002 SHALL have port clk, input, width 1: the single clock; all logic is rising-edge.
REQ-003 SHALL have port preset, input, width 1: synchronous, active-high reset.
REQ-004 SHALL have port req, input, width 4: per-requester transfer request, level-sensitive.
REQ-005 SHALL have port req_wr, input, width 4: per-requester direction; 1 = write, 0 = read.
REQ-006 SHALL have port req_addr, input, width 12: requester i address in bits [3i+2:3i].
REQ-007 SHALL have port req_wdata, input, width 20: requester i write data in bits [5i+4:5i].
REQ-008 SHALL have port penable, input, width 1: APB enable phase, observed from the bus master.
REQ-009 SHALL have port pready, input, width 1: APB slave ready.
REQ-010 SHALL have port prdata, input, width 5: APB read data.
REQ-011 SHALL have port m_new, output, width 1: transfer-start strobe to the APB master.
REQ-012 SHALL have port m_wr, output, width 1: direction to the APB master.
REQ-013 SHALL have port m_addr, output, width 3: address to the APB master.
REQ-014 SHALL have port m_wdata, output, width 5: write data to the APB master.
REQ-015 SHALL have port m_rst, output, width 1: one-cycle abort pulse, ORed into the master's preset.
REQ-016 SHALL have port gnt, output, width 4: one-hot grant, held for the whole transfer.
REQ-017 SHALL have port done, output, width 4: one-cycle completion pulse for the granted requester.
REQ-018 SHALL have port err, output, width 4: one-cycle timeout pulse for the granted requester.
REQ-019 SHALL have port rdata, output, width 5: read data, valid while done is asserted.
REQ-020 SHALL have port busy, output, width 1: high whenever the state is not IDLE.

Function
REQ-021 SHALL implement the FSM states IDLE, ISSUE and WAIT; all outputs are registered.
REQ-022 SHALL, in IDLE with any eligible req, grant round-robin starting at index (last_gnt+1) mod 4, latch the winner's wr/addr/wdata into m_wr/m_addr/m_wdata, set gnt to one-hot, and go to ISSUE.
REQ-023 SHALL assert m_new for exactly one cycle while in ISSUE, then go to WAIT.
REQ-024 SHALL, in WAIT when penable=1 and pready=1, pulse done[idx] on the next cycle, load rdata with prdata for reads or 0 for writes, clear gnt, update last_gnt to idx, and go to IDLE.
REQ-025 SHALL, in WAIT, increment a 4-bit counter on each cycle with penable=1 and pready=0; the counter is cleared on entry to ISSUE.
REQ-026 SHALL, when the counter reaches TIMEOUT and pready=0, pulse m_rst and err[idx] for one cycle, set rdata=0, clear gnt, update last_gnt to idx, and go to IDLE.
REQ-027 SHALL treat a requester as ineligible in any cycle in which its done or err bit is high, so that a held req is not re-granted back-to-back.
REQ-028 SHALL hold the latched command stable from grant until done or err, regardless of changes on req, req_wr, req_addr or req_wdata.
REQ-029 SHALL ignore deassertion of req mid-transfer; the transfer completes and done is still pulsed.
REQ-030 SHALL ignore pready while penable=0; setup-phase pready has no effect.
REQ-031 SHALL leave rdata holding its last value when done is not asserted.
REQ-032 SHALL give a completion and a timeout in the same cycle priority to completion: pready=1 wins.
REQ-033 SHALL start a new grant no earlier than the IDLE cycle following done or err, giving a minimum of 4 cycles between successive m_new pulses.

Reset
REQ-034 SHALL, when preset=1 at a clock edge, force state=IDLE, gnt=0, done=0, err=0, m_new=0, m_rst=0, m_wr=0, m_addr=0, m_wdata=0, rdata=0, busy=0, the counter to 0 and last_gnt=3; this applies from any state, including mid-transfer.
REQ-035 SHALL make requester 0 the highest priority on the first arbitration after reset.

Verification
REQ-036 SHALL be verified with a single write: req=0001, req_wr=0001, addr0=5, wdata0=0x1A, pready=1 in enable -> gnt=0001, one m_new pulse with m_addr=5 and m_wdata=0x1A, then done=0001 and rdata=0.
REQ-037 SHALL be verified with a single read: req=0100 (read), addr2=3, prdata=0x0B at completion -> done=0100 and rdata=0x0B for one cycle.
REQ-038 SHALL be verified with fairness: all four req held high -> grant order 0,1,2,3,0, and no requester is granted twice in succession.
REQ-039 SHALL be verified with a timeout: TIMEOUT=15 and pready held at 0 -> after 15 enable cycles, m_rst=1 and err[idx]=1 for one cycle, then IDLE and the next requester is granted.
REQ-040 SHALL be verified with reset mid-transfer: preset=1 while in WAIT -> all outputs are 0 on the next cycle, and requester 0 is granted first afterward.
REQ-041 SHALL be verified with stability: req_addr and req_wdata toggled during WAIT -> m_addr and m_wdata stay at their latched values until done.
